// File: rtl/console_rx.sv
// Host-to-core console input. Host characters are queued in a FIFO. The core reads
// them back one at a time through a small register window, and a level IRQ signals that data is pending.
module console_rx #(
    parameter int DEPTH    = 16,
    parameter bit BLOCKING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        char_valid_i,
    input  logic [7:0]  char_i,
    output logic        char_ready_o,
    output logic        irq_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          irq_en;
    logic          ovf;

    logic          full;
    logic          empty;
    logic [1:0]    sel;
    logic          rd_en;
    logic          ctrl_wr;
    logic          flush;
    logic          ovf_clr;
    logic          pop;
    logic          offer;
    logic          push;
    logic          drop;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign sel     = addr_i[3:2];
    assign rd_en   = en_i && (we_i == 4'b0000);
    assign ctrl_wr = en_i && we_i[0] && (sel == 2'd2);
    assign flush   = ctrl_wr && data_i[2];
    assign ovf_clr = ctrl_wr && data_i[1];

    // Flush wins over everything in its cycle: the host char is swallowed and any DATA read sees empty.
    assign pop   = rd_en && (sel == 2'd0) && !empty && !flush;
    assign offer = char_valid_i && char_ready_o;
    assign push  = offer && (!full || pop) && !flush;
    assign drop  = offer && full && !pop && !flush;

    assign char_ready_o = BLOCKING ? !full : 1'b1;
    assign irq_o        = irq_en && !empty;

    assign unused_bits = ^{data_i[31:3], addr_i[1:0], we_i[3:1]};

    always_comb begin
        rdata = '0;
        case (sel)
            2'd0:    rdata = (empty || flush) ? 32'h8000_0000 : {24'b0, mem[rd_ptr]};
            2'd1:    rdata = {16'b0, 8'(count), 5'b0, ovf, full, !empty};
            2'd2:    rdata = {31'b0, irq_en};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            irq_en <= 1'b0;
            ovf    <= 1'b0;
            data_o <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
            // Clear first so a same-cycle overflow leaves the flag set.
            if (ovf_clr) ovf <= 1'b0;
            if (drop)    ovf <= 1'b1;
            if (ctrl_wr) irq_en <= data_i[0];
            if (rd_en)   data_o <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= char_i;
    end

endmodule

// File: tb/tb_console_rx.sv
// Scoreboard bench for console_rx: one blocking and one dropping instance share stimulus.
module tb_console_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i;
    logic [3:0]  we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic        char_valid_i;
    logic [7:0]  char_i;
    logic [31:0] data_b, data_n;
    logic        ready_b, ready_n, irq_b, irq_n;
    logic        blk_sel;

    logic [31:0] data_o;
    logic        char_ready;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  model[$];

    always #5 clk = ~clk;

    assign data_o     = blk_sel ? data_b  : data_n;
    assign char_ready = blk_sel ? ready_b : ready_n;
    assign irq        = blk_sel ? irq_b   : irq_n;

    console_rx #(.DEPTH(16), .BLOCKING(1'b1)) dut_blk (
        .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_b), .char_valid_i(char_valid_i),
        .char_i(char_i), .char_ready_o(ready_b), .irq_o(irq_b)
    );

    console_rx #(.DEPTH(16), .BLOCKING(1'b0)) dut_drop (
        .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_n), .char_valid_i(char_valid_i),
        .char_i(char_i), .char_ready_o(ready_n), .irq_o(irq_n)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Every task starts at a falling edge and returns at the next one.
    task automatic do_reset();
        reset = 1'b1;
        en_i = 1'b0; we_i = '0; addr_i = '0; data_i = '0; char_valid_i = 1'b0; char_i = '0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model.delete();
    endtask

    task automatic read_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        en_i = 1'b1; we_i = 4'h0; addr_i = a;
        exp_q.push_back(exp);
        @(negedge clk);
        en_i = 1'b0;
        check(tag, data_o, exp_q.pop_front());
    endtask

    task automatic read_data(input string tag);
        logic [31:0] e;
        e = (model.size() == 0) ? 32'h8000_0000 : {24'b0, model.pop_front()};
        read_reg(tag, 4'h0, e);
    endtask

    task automatic write_ctrl(input logic [31:0] v);
        en_i = 1'b1; we_i = 4'hF; addr_i = 4'h8; data_i = v;
        @(negedge clk);
        en_i = 1'b0; we_i = 4'h0; data_i = '0;
    endtask

    task automatic push_char(input logic [7:0] c);
        char_valid_i = 1'b1; char_i = c;
        @(negedge clk);
        char_valid_i = 1'b0;
        model.push_back(c);
    endtask

    initial begin
        blk_sel = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_data_o", data_o, 32'h0);
        check("rst_ready", {31'b0, char_ready}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        read_reg("rst_status", 4'h4, 32'h0);
        read_data("rst_data_empty");

        // Basic push then pop, plus pop+push while empty
        push_char(8'h41);
        push_char(8'h42);
        read_reg("two_status", 4'h4, 32'h0000_0201);
        read_data("pop_41");
        read_data("pop_42");
        read_data("pop_empty");
        read_reg("drained_status", 4'h4, 32'h0);
        char_valid_i = 1'b1; char_i = 8'h5A;
        read_data("empty_pop_push");
        char_valid_i = 1'b0;
        model.push_back(8'h5A);
        read_data("late_push_lands");

        // Blocking backpressure
        do_reset();
        char_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            char_i = 8'h60 + 8'(i);
            model.push_back(char_i);
            @(negedge clk);
        end
        char_i = 8'h70;
        check("blk_ready_low", {31'b0, char_ready}, 32'h0);
        @(negedge clk);
        check("blk_ready_stays_low", {31'b0, char_ready}, 32'h0);
        read_reg("blk_full_status", 4'h4, 32'h0000_1003);
        read_data("blk_pop_first");
        check("blk_ready_after_pop", {31'b0, char_ready}, 32'h1);
        @(negedge clk);
        char_valid_i = 1'b0;
        model.push_back(8'h70);
        read_reg("blk_refull_status", 4'h4, 32'h0000_1003);
        for (int i = 0; i < 16; i++) read_data("blk_drain");
        read_data("blk_drain_empty");

        // Dropping mode overflow and W1C clear
        blk_sel = 1'b0;
        do_reset();
        char_valid_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            char_i = 8'h30 + 8'(i);
            if (i < 16) model.push_back(char_i);
            @(negedge clk);
        end
        char_valid_i = 1'b0;
        read_reg("ovf_status", 4'h4, 32'h0000_1007);
        write_ctrl(32'h2);
        read_reg("ovf_cleared", 4'h4, 32'h0000_1003);
        for (int i = 0; i < 16; i++) read_data("ovf_drain");
        read_reg("ovf_empty_status", 4'h4, 32'h0);

        // Interrupt timing and flush
        blk_sel = 1'b1;
        do_reset();
        write_ctrl(32'h1);
        read_reg("ctrl_readback", 4'h8, 32'h1);
        check("irq_idle", {31'b0, irq}, 32'h0);
        push_char(8'h55);
        check("irq_rise", {31'b0, irq}, 32'h1);
        read_data("irq_pop");
        check("irq_fall", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 5; i++) push_char(8'hA0 + 8'(i));
        read_reg("pre_flush_status", 4'h4, 32'h0000_0501);
        write_ctrl(32'h5);
        model.delete();
        check("flush_irq", {31'b0, irq}, 32'h0);
        read_reg("flush_status", 4'h4, 32'h0);
        read_data("flush_data_empty");

        // Full dropping FIFO with simultaneous pop and push, then reset mid-push
        blk_sel = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) push_char(8'h80 + 8'(i));
        char_valid_i = 1'b1; char_i = 8'h99;
        read_data("full_pop_push");
        char_valid_i = 1'b0;
        model.push_back(8'h99);
        read_reg("full_pp_status", 4'h4, 32'h0000_1003);
        for (int i = 0; i < 16; i++) read_data("full_pp_drain");
        write_ctrl(32'h1);
        push_char(8'h11);
        push_char(8'h22);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        reset = 1'b1; char_valid_i = 1'b1; char_i = 8'h33;
        @(negedge clk);
        reset = 1'b0; char_valid_i = 1'b0;
        model.delete();
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_ready", {31'b0, char_ready}, 32'h1);
        check("midrst_data_o", data_o, 32'h0);
        read_reg("midrst_status", 4'h4, 32'h0);
        read_data("midrst_data_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
